spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
SPI target that configures the PWM peripheral's five 8-bit control registers from an external SPI controller. Write-only: mode 0, MSB first, one 16-bit frame per nCS assertion. It sits between the SPI pins (ui_in) and pwm_peripheral, and drives en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle. SPI inputs are asynchronous to clk and are synchronized internally.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchronizer (sclk, copi, ncs); legal values ≥2.
MAX_ADDR, 7'h04, highest writable register address; addresses above this are discarded.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  synchronous active-low reset, sampled on clk rising edge
sclk  input  1  SPI serial clock, asynchronous
copi  input  1  SPI controller-out/peripheral-in data, asynchronous
ncs  input  1  SPI chip select, active low, asynchronous
en_reg_out_7_0  output  8  register 0x00: output enables, bits 7:0
en_reg_out_15_8  output  8  register 0x01: output enables, bits 15:8
en_reg_pwm_7_0  output  8  register 0x02: PWM mode enables, bits 7:0
en_reg_pwm_15_8  output  8  register 0x03: PWM mode enables, bits 15:8
pwm_duty_cycle  output  8  register 0x04: duty cycle (0x00 = 0%, 0xFF = 100%)

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all five registers = 0x00;
  - bit counter = 0, shift register = 0, overflow flag = 0;
  - sync chains load idle values: ncs=1, sclk=0, copi=0;
  - edge-detect history flops load the same idle values.
- Synchronizers: each input passes through SYNC_STAGES flops plus one history flop. Edges are detected combinationally from sync output vs history.
  - sclk_rise = sync & ~hist
  - ncs_fall = ~sync & hist
  - ncs_rise = sync & ~hist
- Timing requirement: SCLK high and low phases are each ≥3 clk periods. nCS setup to first SCLK rise, and hold after last SCLK rise, are each ≥3 clk periods. Behaviour outside these limits is undefined.
- States: IDLE (synced ncs=1) and SHIFT (synced ncs=0).
- IDLE -> SHIFT on ncs_fall:
  - bit counter = 0, overflow = 0, shift register = 0;
  - an sclk_rise in the same cycle is ignored.
- In SHIFT, on each sclk_rise:
  - shift register <= {shift[14:0], copi_sync};
  - counter increments;
  - if counter is already 16, counter holds at 16 and overflow = 1.
- SHIFT -> IDLE on ncs_rise. The frame commits only if all of the following hold:
  - counter == 16 and overflow == 0;
  - shift[15] == 1 (write);
  - shift[14:8] ≤ MAX_ADDR.
  On commit, register[shift[14:8]] <= shift[7:0] on the same clk edge that leaves SHIFT. Any other frame (read bit 0, bad address, short or long frame) is discarded with no register change.
- Frame format: bit15 R/W (1 = write, 0 = read; reads are ignored, no COPI/CIPO response), bits14:8 address, bits7:0 data.
- Latency: the register takes its new value on the (SYNC_STAGES+1)th rising clk edge after the nCS pin rises (3rd edge for the default depth). Registers hold value otherwise.
- sclk edges while in IDLE are ignored. Only one register is written per frame. Registers never change except by commit or reset.
- Reset mid-frame: partial frame is lost and registers clear. If nCS is still low after reset is released, the synced ncs 1->0 is treated as ncs_fall. The remaining bits count from 0 and commit only if exactly 16 arrive.
- Back-to-back frames are supported, with nCS high for ≥3 clk periods between frames.

Test Plan:
- After reset, all outputs = 0x00. Frame 0x80F0 (write, addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0 exactly 3 clk edges after nCS rises; other registers stay 0x00.
- Frames 0x8155, 0x82AA, 0x83FF, 0x8480 back-to-back -> regs 0x01..0x04 = 0x55, 0xAA, 0xFF, 0x80; reg 0x00 unchanged.
- Frame 0x00F0 (read bit 0) -> no change. Frame 0xB0CC (addr 0x30 > MAX_ADDR) -> no change to any register.
- 15-bit frame and 17-bit frame each targeting addr 0x04 with data 0x11 -> pwm_duty_cycle keeps its previous value (0x80).
- rst_n pulsed low for 1 clk after the 8th SCLK of frame 0x8377 -> all registers 0x00. The following full frame 0x8201 -> en_reg_pwm_7_0 = 0x01.
- SCLK toggled 16 times with nCS high, then valid frame 0x8122 -> only en_reg_out_15_8 = 0x22.

Source files
------------

// File: rtl/spi_peripheral.sv
// ============================================================================
// spi_peripheral: write-only SPI mode-0 target loading five 8-bit PWM control registers.
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_hist_q, ncs_hist_q;
  logic [4:0]             cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [15:0]            shift_q, shift_d;
  logic                   commit;
  logic [7:0]             reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;

  // Synchronizers reset to the bus idle levels so reset never fabricates an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_hist_q <= 1'b0;
      ncs_hist_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_hist_q <= sclk_s;
      ncs_hist_q  <= ncs_s;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      ovf_q   <= 1'b0;
      shift_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    shift_d = shift_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          cnt_d   = 5'd0;
          ovf_d   = 1'b0;
          shift_d = 16'h0000;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          state_d = IDLE;
          commit  = (cnt_q == 5'd16) && !ovf_q && shift_q[15] &&
                    (shift_q[14:8] <= MAX_ADDR);
        end else if (sclk_rise) begin
          shift_d = {shift_q[14:0], copi_s};
          if (cnt_q == 5'd16) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg0_q <= 8'h00;
      reg1_q <= 8'h00;
      reg2_q <= 8'h00;
      reg3_q <= 8'h00;
      reg4_q <= 8'h00;
    end else if (commit) begin
      case (shift_q[14:8])
        7'h00:   reg0_q <= shift_q[7:0];
        7'h01:   reg1_q <= shift_q[7:0];
        7'h02:   reg2_q <= shift_q[7:0];
        7'h03:   reg3_q <= shift_q[7:0];
        7'h04:   reg4_q <= shift_q[7:0];
        default: ;
      endcase
    end
  end

  assign en_reg_out_7_0  = reg0_q;
  assign en_reg_out_15_8 = reg1_q;
  assign en_reg_pwm_7_0  = reg2_q;
  assign en_reg_pwm_15_8 = reg3_q;
  assign pwm_duty_cycle  = reg4_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
// ============================================================================
// tb_spi_peripheral: directed SPI frames with a queue scoreboard of register images.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

  int errors = 0;
  int checks = 0;

  logic [39:0] model;
  logic [39:0] exp_q[$];
  logic [39:0] obs;

  spi_peripheral dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle)
  );

  always #5 clk = ~clk;

  assign obs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all(input logic [39:0] exp, input string tag);
    for (int r = 0; r < 5; r++) begin
      checks++;
      assert (obs[r*8 +: 8] === exp[r*8 +: 8])
      else begin
        errors++;
        $error("FAIL %s reg%0d observed=%h expected=%h", tag, r, obs[r*8 +: 8], exp[r*8 +: 8]);
      end
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model = '0;
  endtask

  // Bits beyond 16 are sent as 0; rst_at>0 pulses reset in the low phase after that bit.
  task automatic send_frame(input logic [15:0] f, input int nbits, input int rst_at);
    @(negedge clk);
    ncs = 1'b0;
    clks(4);
    for (int i = 0; i < nbits; i++) begin
      copi = (i < 16) ? f[15-i] : 1'b0;
      clks(4);
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
      if (rst_at == i + 1) begin
        pulse_reset();
        check_all(40'h0, "reset_midframe");
        clks(4);
      end
    end
    copi = 1'b0;
    clks(4);
    ncs = 1'b1;
  endtask

  task automatic do_frame(input logic [15:0] f, input int nbits, input int rst_at, input string tag);
    logic [39:0] prev;
    logic [39:0] exp;
    logic [39:0] nxt;
    prev = model;
    nxt  = (rst_at > 0) ? 40'h0 : model;
    if (rst_at == 0 && nbits == 16 && f[15] && f[14:8] <= 7'h04)
      nxt[f[10:8]*8 +: 8] = f[7:0];
    exp_q.push_back(nxt);
    send_frame(f, nbits, rst_at);
    model = nxt;
    if (rst_at > 0) prev = 40'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all(prev, {tag, "_edge2"});
    @(posedge clk); #1;
    checks++;
    assert (exp_q.size() > 0)
    else begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check_all(exp, {tag, "_edge3"});
    end
    clks(3);
  endtask

  initial begin
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs   = 1'b1;
    model = '0;
    clks(3);
    rst_n = 1'b1;
    clks(2);
    check_all(40'h0, "reset");

    do_frame(16'h80F0, 16, 0, "wr0");
    do_frame(16'h8155, 16, 0, "wr1");
    do_frame(16'h82AA, 16, 0, "wr2");
    do_frame(16'h83FF, 16, 0, "wr3");
    do_frame(16'h8480, 16, 0, "wr4");
    do_frame(16'h00F0, 16, 0, "read");
    do_frame(16'hB0CC, 16, 0, "badaddr");
    do_frame(16'h8411, 15, 0, "short");
    do_frame(16'h8411, 17, 0, "long");
    do_frame(16'h8377, 16, 8, "rstmid");
    do_frame(16'h8201, 16, 0, "after_rst");

    for (int i = 0; i < 16; i++) begin
      copi = i[0];
      clks(4);
      sclk = 1'b1;
      clks(4);
      sclk = 1'b0;
    end
    clks(4);
    check_all(model, "idle_sclk");
    do_frame(16'h8122, 16, 0, "wr1_after_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
